prescaled_counter: RTL and testbench

Parametrised single-clock counter that steps once every `CLK_HZ/TICK_HZ` clock cycles. It supersedes the fixed 1 Hz, 4-bit hex counter. Additions over that block: configurable width and terminal value, up/down direction, wrap or saturate mode, synchronous load and clear, and tick/terminal-count strobes. It feeds the seven-segment and timer logic. It generates no derived clock: all state is on `clk`, and the prescaler produces an enable strobe.

---
 rtl/count_pkg.sv | 16 +
 rtl/prescaled_counter_if.sv | 25 ++
 rtl/tick_gen.sv | 32 +++
 rtl/prescaled_counter.sv | 72 +++++++
 tb/tb_prescaled_counter.sv | 128 ++++++++++++
 5 files changed

// File: rtl/count_pkg.sv
// Shared constants and helpers for the counter family
// (prescaled_counter, debounce, display scan).
package count_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Elaboration-time ceil(log2(v)); returns at least 1 so a register is never zero width.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/prescaled_counter_if.sv
// Control/status bundle of prescaled_counter: the host drives the controls
// and observes count and strobes.
interface prescaled_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             up_dn;
  logic             mode;
  logic [WIDTH-1:0] count;
  logic             tick;
  logic             tc;

  modport master (
    output en, clear, load, load_val, up_dn, mode,
    input  count, tick, tc
  );

  modport slave (
    input  en, clear, load, load_val, up_dn, mode,
    output count, tick, tc
  );
endinterface

// File: rtl/tick_gen.sv
// Free-running prescaler: roll is a combinational enable that is high in the
// last cycle of each DIV-cycle period while en is asserted.
module tick_gen
  import count_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clear,
  output logic roll
);

  localparam int            PW   = clog2(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] pre;

  assign roll = en && (pre == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre <= '0;
    end else if (clear || roll) begin
      pre <= '0;
    end else if (en) begin
      pre <= pre + PW'(1);
    end
  end

endmodule

// File: rtl/prescaled_counter.sv
// Counter stepping once every CLK_HZ/TICK_HZ clocks, with up/down, wrap or
// saturate, synchronous load/clear and registered tick/terminal-count strobes.
module prescaled_counter
  import count_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 1,
  parameter int WIDTH   = 4,
  parameter int MAX     = 2**WIDTH - 1
) (
  input  logic                clk,
  input  logic                reset_n,
  prescaled_counter_if.slave  bus
);

  localparam int               DIV   = CLK_HZ / TICK_HZ;
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  generate
    if ((CLK_HZ % TICK_HZ) != 0 || DIV < 2) begin : g_bad_div
      $error("prescaled_counter: CLK_HZ/TICK_HZ must be an integer >= 2");
    end
    if (MAX < 1 || MAX > 2**WIDTH - 1) begin : g_bad_max
      $error("prescaled_counter: MAX must lie in 1 .. 2**WIDTH-1");
    end
  endgenerate

  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return (v > MAX_V) ? MAX_V : v;
  endfunction

  // Boundary is MAX going up, 0 going down; mode only matters at the boundary.
  function automatic logic [WIDTH-1:0] step_val(input logic [WIDTH-1:0] c,
                                                input logic up, input logic sat);
    if (up) return (c == MAX_V) ? (sat ? MAX_V : '0) : c + WIDTH'(1);
    else    return (c == '0)    ? (sat ? '0 : MAX_V) : c - WIDTH'(1);
  endfunction

  logic roll;
  logic at_bound;

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (bus.en),
    .clear   (bus.clear),
    .roll    (roll)
  );

  assign at_bound = bus.up_dn ? (bus.count == MAX_V) : (bus.count == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.count <= '0;
      bus.tick  <= 1'b0;
      bus.tc    <= 1'b0;
    end else if (bus.clear) begin
      bus.count <= '0;
      bus.tick  <= 1'b0;
      bus.tc    <= 1'b0;
    end else if (bus.load) begin
      bus.count <= clamp_load(bus.load_val);
      bus.tick  <= roll;
      bus.tc    <= 1'b0;
    end else begin
      bus.tick <= roll;
      bus.tc   <= roll && at_bound;
      if (roll) bus.count <= step_val(bus.count, bus.up_dn, bus.mode == MODE_SAT);
    end
  end

endmodule

// File: tb/tb_prescaled_counter.sv
// Directed bench: one counter with MAX=15 (up/wrap run) and one with MAX=9
// (saturate, load, clear, enable gap and asynchronous reset cases).
module tb_prescaled_counter;
  import count_pkg::*;

  logic clk = 1'b0;
  logic a_rst_n = 1'b0;
  logic b_rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   ecnt  = 0;

  always #5 clk = ~clk;

  prescaled_counter_if #(.WIDTH(4)) a_if ();
  prescaled_counter_if #(.WIDTH(4)) b_if ();

  prescaled_counter #(.CLK_HZ(10), .TICK_HZ(1), .WIDTH(4), .MAX(15)) dut_a (
    .clk(clk), .reset_n(a_rst_n), .bus(a_if.slave)
  );
  prescaled_counter #(.CLK_HZ(10), .TICK_HZ(1), .WIDTH(4), .MAX(9)) dut_b (
    .clk(clk), .reset_n(b_rst_n), .bus(b_if.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, ecnt);
    end
  endtask

  // Advance to edge n after the last release; sampling point is 1 ns after the edge.
  task automatic run_to(input int n);
    while (ecnt < n) begin
      @(posedge clk);
      #1;
      ecnt++;
    end
  endtask

  initial begin
    a_if.en = 1'b1; a_if.clear = 1'b0; a_if.load = 1'b0; a_if.load_val = '0;
    a_if.up_dn = 1'b1; a_if.mode = MODE_WRAP;
    b_if.en = 1'b1; b_if.clear = 1'b0; b_if.load = 1'b0; b_if.load_val = '0;
    b_if.up_dn = 1'b0; b_if.mode = MODE_SAT;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", a_if.count, 0);
    chk("rst_tick",  a_if.tick,  0);
    chk("rst_tc",    a_if.tc,    0);
    chk("rst_count_b", b_if.count, 0);

    // Up/wrap over 170 cycles: step every 10th edge, tc only on 15->0.
    a_rst_n = 1'b1;
    ecnt = 0;
    for (int c = 1; c <= 170; c++) begin
      run_to(c);
      chk("a_count", a_if.count, (c / 10) % 16);
      chk("a_tick",  a_if.tick,  (c % 10) == 0);
      chk("a_tc",    a_if.tc,    c == 160);
    end
    a_if.en = 1'b0;

    // Down/sat from 3 with MAX=9.
    b_rst_n = 1'b1;
    ecnt = 0;
    run_to(1);  b_if.load = 1'b1; b_if.load_val = 4'd3;
    run_to(2);  b_if.load = 1'b0;
    chk("b_load3", b_if.count, 3);
    run_to(10); chk("b_s1", b_if.count, 2); chk("b_s1_tick", b_if.tick, 1); chk("b_s1_tc", b_if.tc, 0);
    run_to(11); chk("b_tick_len", b_if.tick, 0);
    run_to(20); chk("b_s2", b_if.count, 1);
    run_to(30); chk("b_s3", b_if.count, 0); chk("b_s3_tc", b_if.tc, 0);
    run_to(40); chk("b_s4", b_if.count, 0); chk("b_s4_tc", b_if.tc, 1);
    run_to(41); chk("b_tc_len", b_if.tc, 0);
    run_to(50); chk("b_s5", b_if.count, 0); chk("b_s5_tc", b_if.tc, 1);

    // Over-range load clamps to MAX; load coincident with roll.
    run_to(54); b_if.load = 1'b1; b_if.load_val = 4'd12;
    run_to(55); b_if.load = 1'b0;
    chk("b_clamp", b_if.count, 9); chk("b_clamp_tick", b_if.tick, 0);
    run_to(59); b_if.load = 1'b1; b_if.load_val = 4'd12;
    run_to(60); b_if.load = 1'b0;
    chk("b_ldroll_cnt", b_if.count, 9); chk("b_ldroll_tick", b_if.tick, 1);
    chk("b_ldroll_tc", b_if.tc, 0);

    // Clear coincident with roll at count 5.
    run_to(61); b_if.load = 1'b1; b_if.load_val = 4'd5;
    run_to(62); b_if.load = 1'b0;
    chk("b_load5", b_if.count, 5);
    b_if.up_dn = 1'b1; b_if.mode = MODE_WRAP;
    run_to(69); b_if.clear = 1'b1;
    run_to(70); b_if.clear = 1'b0;
    chk("b_clr_cnt", b_if.count, 0); chk("b_clr_tick", b_if.tick, 0); chk("b_clr_tc", b_if.tc, 0);
    run_to(79); chk("b_clr_79_tick", b_if.tick, 0);
    run_to(80); chk("b_clr_80_tick", b_if.tick, 1); chk("b_clr_80_cnt", b_if.count, 1);

    // Enable low for 7 edges with pre=4: next tick moves from 90 to 97.
    run_to(84); b_if.en = 1'b0;
    for (int e = 85; e <= 91; e++) begin
      run_to(e);
      chk("b_gap_cnt", b_if.count, 1);
      chk("b_gap_tick", b_if.tick, 0);
    end
    b_if.en = 1'b1;
    run_to(96); chk("b_gap_96_tick", b_if.tick, 0); chk("b_gap_96_cnt", b_if.count, 1);
    run_to(97); chk("b_gap_97_tick", b_if.tick, 1); chk("b_gap_97_cnt", b_if.count, 2);

    // Asynchronous reset between edges while count=7 and tick high.
    run_to(106); b_if.load = 1'b1; b_if.load_val = 4'd7;
    run_to(107); b_if.load = 1'b0;
    chk("b_pre_rst_cnt", b_if.count, 7); chk("b_pre_rst_tick", b_if.tick, 1);
    #3 b_rst_n = 1'b0;
    #1;
    chk("b_arst_cnt", b_if.count, 0); chk("b_arst_tick", b_if.tick, 0); chk("b_arst_tc", b_if.tc, 0);
    @(posedge clk);
    #1 b_rst_n = 1'b1;
    ecnt = 0;
    run_to(9);  chk("b_rel_9_tick", b_if.tick, 0); chk("b_rel_9_cnt", b_if.count, 0);
    run_to(10); chk("b_rel_10_tick", b_if.tick, 1); chk("b_rel_10_cnt", b_if.count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
